// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with optional result mailbox
//
// Purpose: word-addressed 32-bit memory that accepts one read or write at a
// time, inserts WAIT_CYCLES wait states, then completes with a one-cycle
// Ready pulse. Optional result mailbox enabled by macro MEM_TRAP_EN.
//
// Parameters:
//   DEPTH       number of 32-bit words (power of two, 4..1024)
//   WAIT_CYCLES wait states before each response (0..15)
//   TRAP_ADDR   byte address of the result mailbox
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous active-low reset
//   Adr        in  32  byte address of request
//   WriteData  in  32  store data
//   MemWrite   in   1  write request
//   MemRead    in   1  read request
//   ReadData   out 32  load data, valid while Ready=1 for a read
//   Ready      out  1  one-cycle completion pulse
//   Busy       out  1  high from acceptance through the Ready cycle
//   trap_valid out  1  mailbox written since reset (MEM_TRAP_EN only)
//   trap_data  out 32  last mailbox value (MEM_TRAP_EN only)

module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int TRAP_ADDR   = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        trap_valid,
  output logic [31:0] trap_data
);

  localparam int         ADDR_W  = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_write_q, is_write_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;

  // Byte address wraps modulo DEPTH*4; the low two bits select nothing.
  assign idx = adr_q[ADDR_W+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (MemWrite || MemRead) begin
          adr_d      = Adr;
          wdata_d    = WriteData;
          // A simultaneous read is dropped in favour of the write.
          is_write_d = MemWrite;
          cnt_d      = WAIT_LD;
          state_d    = (WAIT_LD == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter holds the number of WAIT cycles still to spend, this one included.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        // Latch the presented word so ReadData holds it after the pulse.
        if (!is_write_q) begin
          rdata_d = mem[idx];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      adr_q      <= 32'd0;
      wdata_q    <= 32'd0;
      is_write_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array is never cleared. Reset pins the FSM in IDLE, so a pending write
  // never reaches its RESP edge and is dropped.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && is_write_q) begin
      mem[idx] <= wdata_q;
    end
  end

  assign Ready    = (state_q == S_RESP);
  assign Busy     = (state_q != S_IDLE);
  assign ReadData = (state_q == S_RESP && !is_write_q) ? mem[idx] : rdata_q;

`ifdef MEM_TRAP_EN
  localparam logic [31:0] TRAP_WORD = 32'(TRAP_ADDR);

  logic        trap_valid_q;
  logic [31:0] trap_data_q;
  logic        trap_hit;
  logic        unused_trap_bits;

  assign trap_hit         = (adr_q[31:2] == TRAP_WORD[31:2]);
  assign unused_trap_bits = ^{adr_q[1:0], TRAP_WORD[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_valid_q <= 1'b0;
      trap_data_q  <= 32'd0;
    end else if (state_q == S_RESP && is_write_q && trap_hit) begin
      trap_valid_q <= 1'b1;
      trap_data_q  <= wdata_q;
    end
  end

  assign trap_valid = trap_valid_q;
  assign trap_data  = trap_data_q;
`else
  logic unused_adr_bits;

  assign unused_adr_bits = ^{adr_q[31:ADDR_W+2], adr_q[1:0]};
  assign trap_valid      = 1'b0;
  assign trap_data       = 32'd0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed vector bench for mem_responder
`timescale 1ns/1ps

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  we, re, rdy, busy, tv;
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [31:0] rd  [2];
  logic [31:0] td  [2];

  int npass  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  // Unit 0: WAIT_CYCLES=2, unit 1: WAIT_CYCLES=0.
  mem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .TRAP_ADDR(100)) dut (
    .clk(clk), .reset(reset), .Adr(adr[0]), .WriteData(wd[0]),
    .MemWrite(we[0]), .MemRead(re[0]), .ReadData(rd[0]), .Ready(rdy[0]),
    .Busy(busy[0]), .trap_valid(tv[0]), .trap_data(td[0])
  );

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .TRAP_ADDR(100)) dut0 (
    .clk(clk), .reset(reset), .Adr(adr[1]), .WriteData(wd[1]),
    .MemWrite(we[1]), .MemRead(re[1]), .ReadData(rd[1]), .Ready(rdy[1]),
    .Busy(busy[1]), .trap_valid(tv[1]), .trap_data(td[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Called at a negedge with the unit idle. Returns at the negedge after
  // the Ready cycle. lat counts negedges from acceptance to the Ready sample.
  task automatic txn(input int u, input logic w, input logic r,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] data, output int lat);
    we[u] = w; re[u] = r; adr[u] = a; wd[u] = d;
    lat = -1; data = 32'd0;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check($sformatf("busy_after_accept_u%0d", u), {31'd0, busy[u]}, 32'd1);
        // Garbage on the inputs after acceptance must not disturb the transaction.
        we[u] = 1'b0; re[u] = 1'b0; adr[u] = 32'hFFFF_FFFC; wd[u] = 32'hBAD0_BAD0;
      end
      if (rdy[u]) begin
        data = rd[u];
        lat  = n;
        break;
      end
    end
    @(negedge clk);
    check($sformatf("ready_single_u%0d", u), {31'd0, rdy[u]}, 32'd0);
    adr[u] = 32'd0; wd[u] = 32'd0;
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] data;
    int          lat;
    int          cnt;
    logic [3:0]  pat;

    tbl[0]  = '{1'b1, 1'b0, 32'd96,  32'hDEAD_BEEF, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'd96,  32'd0,         1'b1, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 1'b1, 32'd4,   32'd7,         1'b0, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 32'd4,   32'd0,         1'b1, 32'd7};
    tbl[4]  = '{1'b1, 1'b0, 32'd260, 32'h11,        1'b0, 32'd0};
    tbl[5]  = '{1'b0, 1'b1, 32'd4,   32'd0,         1'b1, 32'h11};
    tbl[6]  = '{1'b0, 1'b1, 32'd7,   32'd0,         1'b1, 32'h11};
    tbl[7]  = '{1'b1, 1'b0, 32'd8,   32'hA5A5_0001, 1'b0, 32'd0};
    tbl[8]  = '{1'b1, 1'b0, 32'd100, 32'd7,         1'b0, 32'd0};
    tbl[9]  = '{1'b0, 1'b1, 32'd100, 32'd0,         1'b1, 32'd7};
    tbl[10] = '{1'b1, 1'b0, 32'd252, 32'hCAFE_F00D, 1'b0, 32'd0};
    tbl[11] = '{1'b0, 1'b1, 32'd508, 32'd0,         1'b1, 32'hCAFE_F00D};

    we = 2'b00; re = 2'b00;
    for (int u = 0; u < 2; u++) begin adr[u] = 32'd0; wd[u] = 32'd0; end
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_ready",      {31'd0, rdy[0]},  32'd0);
    check("reset_busy",       {31'd0, busy[0]}, 32'd0);
    check("reset_readdata",   rd[0],            32'd0);
    check("reset_trap_valid", {31'd0, tv[0]},   32'd0);
    check("reset_trap_data",  td[0],            32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      txn(0, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, data, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
      if (tbl[i].chk) check($sformatf("vec%0d_readdata", i), data, tbl[i].exp);
    end

`ifdef MEM_TRAP_EN
    check("trap_valid", {31'd0, tv[0]}, 32'd1);
    check("trap_data",  td[0],          32'd7);
`else
    check("trap_valid", {31'd0, tv[0]}, 32'd0);
    check("trap_data",  td[0],          32'd0);
`endif

    // Reset in the middle of WAIT for a write of 0x55 to address 8.
    we[0] = 1'b1; adr[0] = 32'd8; wd[0] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy[0]}, 32'd1);
    we[0] = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort_busy_now",     {31'd0, busy[0]}, 32'd0);
    check("abort_ready_now",    {31'd0, rdy[0]},  32'd0);
    check("abort_readdata_now", rd[0],            32'd0);
    check("abort_trap_valid",   {31'd0, tv[0]},   32'd0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rdy[0]) cnt++;
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rdy[0]) cnt++;
    end
    check("abort_ready_pulses", cnt, 32'd0);
    txn(0, 1'b0, 1'b1, 32'd8, 32'd0, data, lat);
    check("abort_read_latency", lat,  32'd3);
    check("abort_read_prior",   data, 32'hA5A5_0001);

    // Zero wait states: single-cycle latency, then a read held for 4 cycles.
    txn(1, 1'b1, 1'b0, 32'd12, 32'h1234, data, lat);
    check("w0_write_latency", lat, 32'd1);
    txn(1, 1'b0, 1'b1, 32'd12, 32'd0, data, lat);
    check("w0_read_latency", lat,  32'd1);
    check("w0_read_data",    data, 32'h1234);
    re[1] = 1'b1; adr[1] = 32'd12;
    pat = 4'd0; cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat[k] = rdy[1];
      if (rdy[1]) begin
        cnt++;
        check($sformatf("w0_held_data%0d", k), rd[1], 32'h1234);
      end
    end
    re[1] = 1'b0;
    check("w0_held_pattern", {28'd0, pat}, 32'h5);
    check("w0_held_count",   cnt,          32'd2);
    @(negedge clk);
    check("w0_idle_after", {31'd0, busy[1]}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning number of 32-bit words in the array (power of two, 4..1024).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each response (0..15).
REQ-003 The block SHALL have parameter TRAP_ADDR, default 100, meaning byte address of the result mailbox.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low (port names clk and reset per codebase; the polarity and synchronicity here are fixed).
REQ-005 Ports: clk  in  1  rising-edge clock.
REQ-006 Ports: reset  in  1  asynchronous active-low reset.
REQ-007 Ports: Adr  in  32  byte address of request.
REQ-008 Ports: WriteData  in  32  store data.
REQ-009 Ports: MemWrite  in  1  write request.
REQ-010 Ports: MemRead  in  1  read request.
REQ-011 Ports: ReadData  out  32  load data, valid only while Ready=1 for a read.
REQ-012 Ports: Ready  out  1  one-cycle completion pulse.
REQ-013 Ports: Busy  out  1  high from acceptance until the Ready cycle inclusive.
REQ-014 Ports: trap_valid, trap_data  out  1/32  mailbox status (REQ-027).

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; reset state IDLE.
REQ-016 In IDLE with MemWrite=1 or MemRead=1, the block SHALL capture Adr, WriteData and the request type on that edge and go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-017 If MemWrite=1 and MemRead=1 in the same cycle, the write SHALL win; the read SHALL be dropped.
REQ-018 WAIT SHALL count WAIT_CYCLES cycles with a 4-bit counter loaded at acceptance, then go to RESP.
REQ-019 RESP SHALL last exactly one cycle with Ready=1, then return to IDLE; total latency from acceptance edge to Ready = WAIT_CYCLES+1 cycles.
REQ-020 Writes SHALL update the array on the clock edge ending the RESP cycle.
REQ-021 Reads SHALL present the array word on ReadData during RESP; ReadData SHALL hold its last value otherwise.
REQ-022 Word index SHALL be Adr[log2(DEPTH)+1:2]; Adr[1:0] ignored; higher bits ignored (addresses wrap modulo DEPTH*4).
REQ-023 Input changes after acceptance SHALL be ignored until IDLE; no request is accepted in WAIT or RESP.
REQ-024 A request held high through RESP SHALL be accepted again in the following IDLE cycle (back-to-back period = WAIT_CYCLES+2).
REQ-025 A read of a word written by the previous transaction SHALL return the new data.

Reset
REQ-026 reset low SHALL immediately force IDLE, Ready=0, Busy=0, ReadData=0, counter=0, trap_valid=0, trap_data=0; a pending write SHALL be aborted without updating the array; array contents SHALL NOT be cleared.

Configuration
REQ-027 With macro MEM_TRAP_EN defined, a write whose word-aligned address equals TRAP_ADDR SHALL, at the RESP edge, set trap_data=WriteData and trap_valid=1 (sticky until reset) and also update the array; a later trap write SHALL overwrite trap_data.
REQ-028 Without MEM_TRAP_EN, TRAP_ADDR SHALL be ordinary memory and trap_valid/trap_data SHALL be tied to 0.

Verification
REQ-029 Reset low mid-WAIT of write 0x55 to Adr 8 -> Ready never pulses, Busy=0 immediately, later read of Adr 8 returns prior value.
REQ-030 WAIT_CYCLES=2: write 0xDEADBEEF to Adr 96, then read Adr 96 -> each Ready 3 cycles after acceptance, ReadData=0xDEADBEEF.
REQ-031 WAIT_CYCLES=0: MemRead held high 4 cycles -> Ready every 2nd cycle, 2 accepted reads.
REQ-032 MemWrite=1 and MemRead=1 together, Adr 4, WriteData 7 -> write performed, Ready once, subsequent read of Adr 4 returns 7.
REQ-033 DEPTH=64: write 0x11 to Adr 260 -> read of Adr 4 returns 0x11; Adr 7 reads same word as Adr 4.
REQ-034 MEM_TRAP_EN: write 7 to Adr 100 -> trap_valid=1, trap_data=7 after Ready; without macro -> trap_valid stays 0, read of Adr 100 returns 7.
